serial_shift_controller: RTL

//   Multi-cycle barrel-shift replacement for area-constrained builds. Rather than
//   N ripple stages, it holds one data register and applies a single-position

---
 rtl/serial_shift_controller.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_shift_controller.sv
// Multi-cycle shifter: one data register shifted a position per cycle until the amount is used up.
// Optional build macro SERIAL_SHIFT_STRIDE4_EN lets SHIFT consume 4 positions per cycle while count>=4.
module serial_shift_controller #(
  parameter int N = 32,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [1:0]    op_q, op_d;
  logic [SW-1:0] count_q, count_d;

  // One shift step of amt positions; op 11 falls into the SLL default.
  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d, input logic [1:0] op,
                                            input logic [2:0] amt);
    logic [N-1:0] r;
    case (op)
      2'b01:   r = d >> amt;
      2'b10:   r = $signed(d) >>> amt;
      default: r = d << amt;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;
  assign busy      = (state_q != S_IDLE);

  // Next-state logic. A zero amount spends one idle SHIFT cycle so latency is max(shamt,1).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          op_d    = in_op;
          count_d = in_shamt;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
`ifdef SERIAL_SHIFT_STRIDE4_EN
        if ({1'b0, count_q} >= (SW+1)'(4)) begin
          data_d  = shift_by(data_q, op_q, 3'd4);
          count_d = count_q - SW'(4);
        end else if (count_q != '0) begin
          data_d  = shift_by(data_q, op_q, 3'd1);
          count_d = count_q - SW'(1);
        end else begin
          count_d = count_q;
        end
        if (count_d == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
`else
        if (count_q != '0) begin
          data_d  = shift_by(data_q, op_q, 3'd1);
          count_d = count_q - SW'(1);
        end else begin
          count_d = count_q;
        end
        if (count_q <= SW'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      op_q    <= 2'b00;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

endmodule
